// File: rtl/dram_arbiter_if.sv
// Master-side bus of the DRAM arbiter: per-master beat requests/commands,
// grants, and the shared read-return channel.
interface dram_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32
) ();

  logic [NUM_MASTERS-1:0]                 i_req;
  logic [NUM_MASTERS-1:0]                 i_we;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] i_addr;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] i_wdata;
  logic [NUM_MASTERS-1:0]                 o_gnt;
  logic [NUM_MASTERS-1:0]                 o_rvalid;
  logic [DATA_WIDTH-1:0]                  o_rdata;

  // Seen from the requesting blocks
  modport master (
    output i_req, i_we, i_addr, i_wdata,
    input  o_gnt, o_rvalid, o_rdata
  );

  // Seen from the arbiter
  modport slave (
    input  i_req, i_we, i_addr, i_wdata,
    output o_gnt, o_rvalid, o_rdata
  );

endinterface

// File: rtl/dram_arbiter.sv
// Round-robin DRAM port arbiter with burst lock and beat cap; issues registered
// DRAM commands and steers read data back through a latency-matched tag pipe.
module dram_arbiter #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_BURST   = 8,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic                           clk,
  input  logic                           glbl_rst_n,
  dram_arbiter_if.slave                  bus,
  output logic                           o_dram_valid,
  output logic                           o_dram_we,
  output logic [ADDR_WIDTH-1:0]          o_dram_addr,
  output logic [DATA_WIDTH-1:0]          o_dram_wdata,
  input  logic [DATA_WIDTH-1:0]          i_dram_rdata,
  output logic                           o_busy,
  output logic [$clog2(NUM_MASTERS)-1:0] o_owner
);

  localparam int unsigned IDW = $clog2(NUM_MASTERS);
  localparam int unsigned BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [0:0] ST_ARB = 1'b0;
  localparam logic [0:0] ST_OWN = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [IDW-1:0]         owner_q, owner_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]          beat_cnt_q, beat_cnt_d;

  logic [IDW-1:0]         pick;
  logic                   pick_vld;
  logic [NUM_MASTERS-1:0] gnt_c;
  logic [NUM_MASTERS-1:0] owner_oh;
  logic                   others_req;
  logic                   cap_hit;

  logic                   dram_valid_q, dram_valid_d;
  logic                   dram_we_q, dram_we_d;
  logic [ADDR_WIDTH-1:0]  dram_addr_q, dram_addr_d;
  logic [DATA_WIDTH-1:0]  dram_wdata_q, dram_wdata_d;

  logic [RD_LATENCY-1:0]          tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0][IDW-1:0] tag_id_q, tag_id_d;
  logic [NUM_MASTERS-1:0]         rvalid_q, rvalid_d;
  logic                           busy_q, busy_d;

  // Modulo-NUM_MASTERS increment of a master index
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                              input int unsigned    off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
    return IDW'(s);
  endfunction

  // First requester found searching cyclically from rr_ptr
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!pick_vld && bus.i_req[wrap_add(rr_ptr_q, i)]) begin
        pick     = wrap_add(rr_ptr_q, i);
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state, grant, command and tag-pipeline logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    gnt_c        = '0;
    owner_oh     = NUM_MASTERS'(1) << owner_q;
    others_req   = |(bus.i_req & ~owner_oh);
    cap_hit      = (beat_cnt_q == BW'(MAX_BURST - 1));
    dram_valid_d = 1'b0;
    dram_we_d    = 1'b0;
    dram_addr_d  = dram_addr_q;
    dram_wdata_d = dram_wdata_q;
    tag_vld_d    = '0;
    tag_id_d     = '0;
    rvalid_d     = '0;
    busy_d       = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (pick_vld) begin
          state_d    = ST_OWN;
          owner_d    = pick;
          beat_cnt_d = '0;
        end
      end
      ST_OWN: begin
        if (!bus.i_req[owner_q]) begin
          state_d    = ST_ARB;
          owner_d    = '0;
          rr_ptr_d   = wrap_add(owner_q, 1);
          beat_cnt_d = '0;
        end else begin
          gnt_c = owner_oh;
          if (cap_hit && others_req) begin
            state_d    = ST_ARB;
            owner_d    = '0;
            rr_ptr_d   = wrap_add(owner_q, 1);
            beat_cnt_d = '0;
          end else begin
            // A lone requester keeps the port; the counter just wraps
            beat_cnt_d = cap_hit ? '0 : beat_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = ST_ARB;
    endcase

    if (|gnt_c) begin
      dram_valid_d = 1'b1;
      dram_we_d    = bus.i_we[owner_q];
      dram_addr_d  = bus.i_addr[owner_q];
      dram_wdata_d = bus.i_wdata[owner_q];
    end

    // Stage 0 lines up with the command on the pins; o_rvalid is one stage past the end
    tag_vld_d[0] = (|gnt_c) && !bus.i_we[owner_q];
    tag_id_d[0]  = owner_q;
    for (int unsigned k = 1; k < RD_LATENCY; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
    if (tag_vld_q[RD_LATENCY-1]) begin
      rvalid_d = NUM_MASTERS'(1) << tag_id_q[RD_LATENCY-1];
    end

    busy_d = (state_d == ST_OWN) || (|tag_vld_d);
  end

  always_ff @(posedge clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      state_q      <= ST_ARB;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      dram_valid_q <= 1'b0;
      dram_we_q    <= 1'b0;
      dram_addr_q  <= '0;
      dram_wdata_q <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      rvalid_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      dram_valid_q <= dram_valid_d;
      dram_we_q    <= dram_we_d;
      dram_addr_q  <= dram_addr_d;
      dram_wdata_q <= dram_wdata_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      rvalid_q     <= rvalid_d;
      busy_q       <= busy_d;
    end
  end

  // Read data is forced to zero outside a return cycle so idle/reset shows 0
  assign bus.o_gnt    = gnt_c;
  assign bus.o_rvalid = rvalid_q;
  assign bus.o_rdata  = (|rvalid_q) ? i_dram_rdata : '0;

  assign o_dram_valid = dram_valid_q;
  assign o_dram_we    = dram_we_q;
  assign o_dram_addr  = dram_addr_q;
  assign o_dram_wdata = dram_wdata_q;
  assign o_busy       = busy_q;
  assign o_owner      = owner_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: two instances (read latency 1 and 3) share stimulus;
// expected commands and read returns are queued at grant time and popped by a monitor.
module tb_dram_arbiter;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] data;
  } rd_t;

  logic clk;
  logic glbl_rst_n;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  cmd_t cmd_q[$];
  rd_t  rd1_q[$];
  rd_t  rd3_q[$];
  cmd_t ce;
  rd_t  re;

  logic        d1_valid, d1_we, d1_busy, d3_valid, d3_we, d3_busy;
  logic [31:0] d1_addr, d1_wdata, d3_addr, d3_wdata;
  logic [1:0]  d1_owner, d3_owner;
  logic [31:0] p1;
  logic [2:0][31:0] p3;

  dram_arbiter_if #(.NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  dram_arbiter_if #(.NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

  assign bus3.i_req   = bus1.i_req;
  assign bus3.i_we    = bus1.i_we;
  assign bus3.i_addr  = bus1.i_addr;
  assign bus3.i_wdata = bus1.i_wdata;

  dram_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                 .MAX_BURST(8), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .glbl_rst_n(glbl_rst_n), .bus(bus1),
    .o_dram_valid(d1_valid), .o_dram_we(d1_we), .o_dram_addr(d1_addr),
    .o_dram_wdata(d1_wdata), .i_dram_rdata(p1), .o_busy(d1_busy), .o_owner(d1_owner)
  );

  dram_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                 .MAX_BURST(8), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .glbl_rst_n(glbl_rst_n), .bus(bus3),
    .o_dram_valid(d3_valid), .o_dram_we(d3_we), .o_dram_addr(d3_addr),
    .o_dram_wdata(d3_wdata), .i_dram_rdata(p3[2]), .o_busy(d3_busy), .o_owner(d3_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dram_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // DRAM model: data for the address on the pins, returned RD_LATENCY cycles later
  always @(posedge clk) begin
    p1 <= dram_f(d1_addr);
    p3 <= {p3[1:0], dram_f(d3_addr)};
  end

  function automatic logic [31:0] wd(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cmd(input int m, input logic req, input logic we, input logic [31:0] a);
    bus1.i_req[m]   = req;
    bus1.i_we[m]    = we;
    bus1.i_addr[m]  = a;
    bus1.i_wdata[m] = wd(a);
  endtask

  task automatic push_beat(input int m, input logic we, input logic [31:0] a);
    cmd_q.push_back('{cyc + 1, we, a, wd(a)});
    if (!we) begin
      rd1_q.push_back('{cyc + 2, m, dram_f(a)});
      rd3_q.push_back('{cyc + 4, m, dram_f(a)});
    end
  endtask

  // Scoreboard monitor for DRAM commands and read returns
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      checks++;
      if (cmd_q.size() != 0 && cmd_q[0].cyc <= cyc) begin
        ce = cmd_q.pop_front();
        if (ce.cyc != cyc || d1_valid !== 1'b1 || d3_valid !== 1'b1 ||
            d1_we !== ce.we || d3_we !== ce.we || d1_addr !== ce.addr || d3_addr !== ce.addr ||
            (ce.we && (d1_wdata !== ce.wdata || d3_wdata !== ce.wdata))) begin
          errors++;
          $display("FAIL dram_cmd cyc=%0d got v=%b/%b we=%b/%b a=%h/%h d=%h/%h want cyc=%0d we=%b a=%h d=%h",
                   cyc, d1_valid, d3_valid, d1_we, d3_we, d1_addr, d3_addr, d1_wdata, d3_wdata,
                   ce.cyc, ce.we, ce.addr, ce.wdata);
        end
      end else if (d1_valid !== 1'b0 || d3_valid !== 1'b0 || d1_we !== 1'b0 || d3_we !== 1'b0) begin
        errors++;
        $display("FAIL dram_idle cyc=%0d got v=%b/%b we=%b/%b want 0", cyc, d1_valid, d3_valid, d1_we, d3_we);
      end

      checks++;
      if (rd1_q.size() != 0 && rd1_q[0].cyc <= cyc) begin
        re = rd1_q.pop_front();
        if (re.cyc != cyc || bus1.o_rvalid !== 3'(1 << re.id) || bus1.o_rdata !== re.data) begin
          errors++;
          $display("FAIL rd_lat1 cyc=%0d got rvalid=%b rdata=%h want cyc=%0d id=%0d rdata=%h",
                   cyc, bus1.o_rvalid, bus1.o_rdata, re.cyc, re.id, re.data);
        end
      end else if (bus1.o_rvalid !== 3'b000) begin
        errors++;
        $display("FAIL rd_lat1_idle cyc=%0d got rvalid=%b want 000", cyc, bus1.o_rvalid);
      end

      checks++;
      if (rd3_q.size() != 0 && rd3_q[0].cyc <= cyc) begin
        re = rd3_q.pop_front();
        if (re.cyc != cyc || bus3.o_rvalid !== 3'(1 << re.id) || bus3.o_rdata !== re.data) begin
          errors++;
          $display("FAIL rd_lat3 cyc=%0d got rvalid=%b rdata=%h want cyc=%0d id=%0d rdata=%h",
                   cyc, bus3.o_rvalid, bus3.o_rdata, re.cyc, re.id, re.data);
        end
      end else if (bus3.o_rvalid !== 3'b000) begin
        errors++;
        $display("FAIL rd_lat3_idle cyc=%0d got rvalid=%b want 000", cyc, bus3.o_rvalid);
      end
    end
  end

  task automatic test_reset();
    #1;
    checks++;
    if ({bus1.o_gnt, bus1.o_rvalid, bus1.o_rdata, d1_valid, d1_we, d1_addr, d1_wdata, d1_busy, d1_owner} !== '0) begin
      errors++;
      $display("FAIL reset_lat1 got gnt=%b rv=%b rd=%h v=%b we=%b a=%h d=%h busy=%b own=%0d want all 0",
               bus1.o_gnt, bus1.o_rvalid, bus1.o_rdata, d1_valid, d1_we, d1_addr, d1_wdata, d1_busy, d1_owner);
    end
    checks++;
    if ({bus3.o_gnt, bus3.o_rvalid, bus3.o_rdata, d3_valid, d3_we, d3_addr, d3_wdata, d3_busy, d3_owner} !== '0) begin
      errors++;
      $display("FAIL reset_lat3 got gnt=%b rv=%b rd=%h v=%b we=%b a=%h d=%h busy=%b own=%0d want all 0",
               bus3.o_gnt, bus3.o_rvalid, bus3.o_rdata, d3_valid, d3_we, d3_addr, d3_wdata, d3_busy, d3_owner);
    end
  endtask

  task automatic test_round_robin();
    int g[3]   = '{1, 4, 7};
    int own[9] = '{0, 0, 0, 0, 1, 1, 0, 2, 2};
    logic [2:0] exp;
    for (int k = 0; k < 9; k++) begin
      exp = '0;
      for (int m = 0; m < 3; m++) begin
        set_cmd(m, k <= g[m], m != 1, 32'h200 + 32'(m * 4));
        if (k == g[m]) exp[m] = 1'b1;
      end
      #1;
      checks++;
      if (bus1.o_gnt !== exp || bus3.o_gnt !== exp) begin
        errors++;
        $display("FAIL rr_gnt k=%0d got %b/%b want %b", k, bus1.o_gnt, bus3.o_gnt, exp);
      end
      checks++;
      if (d1_owner !== 2'(own[k]) || d3_owner !== 2'(own[k])) begin
        errors++;
        $display("FAIL rr_owner k=%0d got %0d/%0d want %0d", k, d1_owner, d3_owner, own[k]);
      end
      for (int m = 0; m < 3; m++)
        if (k == g[m]) push_beat(m, m != 1, 32'h200 + 32'(m * 4));
      tick();
    end
  endtask

  task automatic test_starvation();
    int bn[3] = '{0, 0, 0};
    int o;
    logic [2:0] exp;
    for (int k = 0; k < 28; k++) begin
      set_cmd(0, k < 27, 1'b1, 32'h1000 + 32'(bn[0] * 4));
      set_cmd(2, k < 27, 1'b0, 32'h2000 + 32'(bn[2] * 4));
      o   = ((k / 9) % 2 == 0) ? 0 : 2;
      exp = (k % 9 == 0 || k == 27) ? 3'b000 : 3'(1 << o);
      #1;
      checks++;
      if (bus1.o_gnt !== exp || bus3.o_gnt !== exp) begin
        errors++;
        $display("FAIL starve_gnt k=%0d got %b/%b want %b", k, bus1.o_gnt, bus3.o_gnt, exp);
      end
      if (exp != 3'b000) begin
        push_beat(o, o == 0, (o == 0 ? 32'h1000 : 32'h2000) + 32'(bn[o] * 4));
        bn[o]++;
      end
      tick();
    end
  endtask

  task automatic test_solo_burst();
    int bn = 0;
    logic [2:0] exp;
    for (int k = 0; k < 22; k++) begin
      set_cmd(1, k <= 20, 1'b1, 32'h3000 + 32'(bn * 4));
      exp = (k >= 1 && k <= 20) ? 3'b010 : 3'b000;
      #1;
      checks++;
      if (bus1.o_gnt !== exp || bus3.o_gnt !== exp) begin
        errors++;
        $display("FAIL solo_gnt k=%0d got %b/%b want %b", k, bus1.o_gnt, bus3.o_gnt, exp);
      end
      if (exp != 3'b000) begin
        push_beat(1, 1'b1, 32'h3000 + 32'(bn * 4));
        bn++;
      end
      tick();
    end
  endtask

  task automatic test_single_master();
    logic       we_tab[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] exp;
    int         i;
    for (int k = 0; k < 8; k++) begin
      i = (k == 0) ? 0 : ((k > 6) ? 5 : k - 1);
      // Before the grant the command is junk; only the grant-cycle value counts
      set_cmd(0, k <= 6, we_tab[i], (k == 0) ? 32'hBAD0 : 32'h100 + 32'(i * 4));
      exp = (k >= 1 && k <= 6) ? 3'b001 : 3'b000;
      #1;
      checks++;
      if (bus1.o_gnt !== exp || bus3.o_gnt !== exp) begin
        errors++;
        $display("FAIL single_gnt k=%0d got %b/%b want %b", k, bus1.o_gnt, bus3.o_gnt, exp);
      end
      if (k == 1) begin
        checks++;
        if (d1_busy !== 1'b1 || d3_busy !== 1'b1) begin
          errors++;
          $display("FAIL single_busy got %b/%b want 1", d1_busy, d3_busy);
        end
      end
      if (exp != 3'b000) push_beat(0, we_tab[i], 32'h100 + 32'(i * 4));
      tick();
    end
    repeat (5) tick();
    #1;
    checks++;
    if (d1_busy !== 1'b0 || d3_busy !== 1'b0 || d1_owner !== 2'd0 || d3_owner !== 2'd0) begin
      errors++;
      $display("FAIL single_idle got busy=%b/%b owner=%0d/%0d want 0", d1_busy, d3_busy, d1_owner, d3_owner);
    end
  endtask

  task automatic test_read_tagging();
    logic [2:0] exp;
    for (int k = 0; k < 5; k++) begin
      set_cmd(2, k <= 3, 1'b0, 32'h4000 + 32'(((k == 0) ? 0 : k - 1) * 4));
      exp = (k >= 1 && k <= 3) ? 3'b100 : 3'b000;
      #1;
      checks++;
      if (bus1.o_gnt !== exp || bus3.o_gnt !== exp) begin
        errors++;
        $display("FAIL tag_gnt k=%0d got %b/%b want %b", k, bus1.o_gnt, bus3.o_gnt, exp);
      end
      if (exp != 3'b000) push_beat(2, 1'b0, 32'h4000 + 32'((k - 1) * 4));
      tick();
    end
    repeat (6) tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [2:0] exp;
    for (int k = 0; k < 3; k++) begin
      set_cmd(0, 1'b1, 1'b0, 32'h5000 + 32'(((k == 0) ? 0 : k - 1) * 4));
      exp = (k == 0) ? 3'b000 : 3'b001;
      #1;
      checks++;
      if (bus1.o_gnt !== exp || bus3.o_gnt !== exp) begin
        errors++;
        $display("FAIL rst_pre_gnt k=%0d got %b/%b want %b", k, bus1.o_gnt, bus3.o_gnt, exp);
      end
      if (exp != 3'b000) push_beat(0, 1'b0, 32'h5000 + 32'((k - 1) * 4));
      tick();
    end
    mon_en = 1'b0;
    cmd_q.delete();
    rd1_q.delete();
    rd3_q.delete();
    glbl_rst_n = 1'b0;
    set_cmd(0, 1'b0, 1'b0, 32'h0);
    test_reset();
    tick();
    tick();
    glbl_rst_n = 1'b1;
    mon_en     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_cmd(0, k <= 1, 1'b1, 32'h6000);
      exp = (k == 1) ? 3'b001 : 3'b000;
      #1;
      checks++;
      if (bus1.o_gnt !== exp || bus3.o_gnt !== exp) begin
        errors++;
        $display("FAIL rst_post_gnt k=%0d got %b/%b want %b", k, bus1.o_gnt, bus3.o_gnt, exp);
      end
      if (exp != 3'b000) push_beat(0, 1'b1, 32'h6000);
      tick();
    end
    repeat (6) tick();
  endtask

  initial begin
    int w;
    glbl_rst_n   = 1'b0;
    bus1.i_req   = '0;
    bus1.i_we    = '0;
    bus1.i_addr  = '0;
    bus1.i_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    glbl_rst_n = 1'b1;
    mon_en     = 1'b1;
    tick();
    test_round_robin();
    test_starvation();
    test_solo_burst();
    test_single_master();
    test_read_tagging();
    test_reset_mid_burst();

    w = 0;
    while ((cmd_q.size() + rd1_q.size() + rd3_q.size()) != 0 && w < 20) begin
      tick();
      w++;
    end
    #3;
    checks++;
    if ((cmd_q.size() + rd1_q.size() + rd3_q.size()) != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d/%0d pending want 0", cmd_q.size(), rd1_q.size(), rd3_q.size());
    end
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single main-memory (DRAM) port between the GPU's memory masters: 0 vertex_fetch, 1 shader_core, 2 framebuffer.
- Round-robin arbitration with burst lock and a beat cap prevents starvation.
- Issues registered DRAM commands and returns read data to the issuing master using a latency-matched tag pipeline.
- Sits between the master blocks and the DRAM pins at the GPU top level.

Parameters:
NUM_MASTERS, 3, number of requesters (>=2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
MAX_BURST, 8, max consecutive granted beats while another master waits (>=1)
RD_LATENCY, 1, cycles from a DRAM read command on the pins to valid i_dram_rdata (>=1)

Ports:
clk  in  1  clock
glbl_rst_n  in  1  reset, asynchronous, active-low
i_req  in  NUM_MASTERS  per-master beat request; held with its command until granted
i_we  in  NUM_MASTERS  per-master write (1) / read (0)
i_addr  in  NUM_MASTERS x ADDR_WIDTH  per-master address
i_wdata  in  NUM_MASTERS x DATA_WIDTH  per-master write data
o_gnt  out  NUM_MASTERS  one-hot; beat accepted this cycle (combinational)
o_rvalid  out  NUM_MASTERS  one-hot; read data valid for that master
o_rdata  out  DATA_WIDTH  shared read data
o_dram_valid  out  1  DRAM command valid
o_dram_we  out  1  DRAM write enable
o_dram_addr  out  ADDR_WIDTH  DRAM address
o_dram_wdata  out  DATA_WIDTH  DRAM write data
i_dram_rdata  in  DATA_WIDTH  DRAM read data
o_busy  out  1  state != ARB or reads outstanding
o_owner  out  $clog2(NUM_MASTERS)  current owner index (0 in ARB)

Behaviour:
- Reset:
  - All outputs 0.
  - State ARB, rr_ptr=0, beat_cnt=0, read tag pipeline cleared.
  - Reset mid-burst or with reads outstanding discards all in-flight reads; no o_rvalid after reset release for reads issued before reset.
- State ARB:
  - o_gnt=0.
  - If any i_req is set, owner = first set bit searching cyclically from rr_ptr; go to OWN next cycle; beat_cnt=0.
  - Arbitration costs 1 bubble cycle.
- State OWN:
  - o_gnt[owner] = i_req[owner]; all other grants 0.
  - Each granted beat increments beat_cnt.
- Release from OWN to ARB, with rr_ptr=(owner+1) mod NUM_MASTERS:
  - i_req[owner]==0 in a cycle (no grant that cycle); or
  - a granted beat with beat_cnt==MAX_BURST-1 while any other i_req is set.
- If beat_cnt reaches MAX_BURST-1 on a granted beat with no other requester, beat_cnt wraps to 0 and ownership is kept.
- Command issue:
  - A beat granted in cycle t appears on o_dram_valid/we/addr/wdata in cycle t+1 (registered).
  - With no grant in cycle t, o_dram_valid=0 in t+1; addr/wdata hold their last value; we=0.
- Read return:
  - For a read on the pins in cycle c, o_rvalid[id] is set in cycle c+RD_LATENCY.
  - o_rdata = i_dram_rdata in that cycle (combinational passthrough).
  - Tag pipeline: RD_LATENCY-deep shift register of {valid, id}; reads may be issued back-to-back.
- Writes produce no o_rvalid.
- A master dropping i_req the same cycle it would be granted receives no grant.
- Changing i_we/i_addr/i_wdata while i_req is high and ungranted is legal; the values in the grant cycle are used.
- o_busy: state==OWN or any tag valid.

Test Plan:
- Single master 2 reads 4 writes, RD_LATENCY=1: i_req[0]=1, addr 0x100..0x114 → ARB bubble 1 cycle; o_gnt[0] for 6 consecutive cycles; DRAM addrs in order one cycle later; o_rvalid[0] twice, each 1 cycle after its read command; o_rdata matches DRAM.
- Starvation cap, MAX_BURST=8: master 0 and master 2 requesting continuously → 8 grants to 0, 1 bubble, 8 grants to 2, 1 bubble, repeat; master 1 never granted.
- Round robin: all three request 1 beat each, then drop → grant order 0,1,2, each separated by a bubble; rr_ptr returns to 0.
- Solo long burst: master 1 requests 20 beats alone → 20 consecutive grants with no bubble (beat_cnt wraps).
- Read tagging, RD_LATENCY=3: master 2 issues 3 back-to-back reads → o_rvalid[2] in 3 consecutive cycles starting 3 cycles after the first command; no o_rvalid on other masters.
- Reset mid-burst: assert glbl_rst_n low with 2 reads outstanding → all outputs 0 immediately; after release no stale o_rvalid; a fresh request from master 0 is granted after the 1-cycle bubble.
